// File: rtl/sum7_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer:
// FSM state encoding and default limb geometry.
package sum7_pkg;

  localparam int DEF_W     = 7;
  localparam int DEF_LIMBS = 4;
  localparam int IDX_W     = (DEF_LIMBS > 1) ? $clog2(DEF_LIMBS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sum_7r.sv
// W-bit ripple-carry adder (7 bits by default); the single shared datapath
// adder driven by the sequencer.
module sum_7r #(
  parameter int W = 7
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Ci,
  output logic [W-1:0] S,
  output logic         Co
);

  logic carry;

  always_comb begin
    S     = '0;
    carry = Ci;
    // NOTE: blocking assignments here are intentional; 'carry' is a
    // combinational temporary that ripples bit to bit within one evaluation.
    for (int i = 0; i < W; i++) begin
      S[i]  = A[i] ^ B[i] ^ carry;
      carry = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
    end
    Co = carry;
  end

endmodule

// File: rtl/sum7_seq_ctrl.sv
// Multi-precision add/subtract sequencer: streams LIMBS limbs of W bits
// through one shared sum_7r adder, LSB limb first, carry chained in a register.
module sum7_seq_ctrl
  import sum7_pkg::*;
#(
  parameter  int W     = DEF_W,
  parameter  int LIMBS = DEF_LIMBS,   // must be >= 2
  localparam int N     = W * LIMBS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] op_a,
  input  logic [N-1:0] op_b,
  input  logic         cin,
  input  logic         sub,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         cout,
  output logic         ovf
);

  localparam int IW = (LIMBS > 1) ? $clog2(LIMBS) : 1;

  state_t         state, state_nx;
  logic [N-1:0]   a_q, b_q, res_q;
  logic [IW-1:0]  idx;
  logic           carry_q, cout_q, ovf_q;
  logic [W-1:0]   sum_s;
  logic           co_s;
  logic           last;

  // Operands shift right one limb per RUN cycle, so the adder always sees bit 0 up.
  sum_7r #(.W(W)) u_adder (
    .A  (a_q[W-1:0]),
    .B  (b_q[W-1:0]),
    .Ci (carry_q),
    .S  (sum_s),
    .Co (co_s)
  );

  assign last = (idx == IW'(LIMBS - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    // NOTE: default assigned first so every path drives state_nx; no latch.
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (last)  state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          a_q     <= op_a;
          b_q     <= sub ? ~op_b : op_b;
          carry_q <= sub | cin;
          idx     <= '0;
          res_q   <= '0;
        end
        S_RUN: begin
          a_q     <= a_q >> W;
          b_q     <= b_q >> W;
          carry_q <= co_s;
          idx     <= idx + IW'(1);
          // Result fills from the top; after LIMBS cycles limb 0 sits at the bottom.
          res_q   <= {sum_s, res_q[N-1:W]};
          if (last) begin
            cout_q <= co_s;
            // Top limb is now at bit 0 of the shifted operands: W-1 is the sign.
            ovf_q  <= (a_q[W-1] == b_q[W-1]) && (sum_s[W-1] != a_q[W-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state == S_RUN);
  assign done   = (state == S_DONE);
  assign result = res_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_sum7_seq_ctrl.sv
// Self-checking bench for sum7_seq_ctrl: directed protocol steps plus random
// operands compared against an arithmetic reference model.
module tb_sum7_seq_ctrl;
  import sum7_pkg::*;

  localparam int W     = DEF_W;
  localparam int LIMBS = DEF_LIMBS;
  localparam int N     = W * LIMBS;

  logic         clk = 1'b0;
  logic         rst, start, cin, sub;
  logic [N-1:0] op_a, op_b;
  logic         busy, done, cout, ovf;
  logic [N-1:0] result;

  int checks = 0;
  int errors = 0;

  sum7_seq_ctrl #(.W(W), .LIMBS(LIMBS)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .cin    (cin),
    .sub    (sub),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] rnd();
    logic [31:0] r;
    r = $urandom();
    return r[N-1:0];
  endfunction

  // Reference: {ovf, cout, result} from plain N-bit two's-complement arithmetic.
  function automatic logic [N+1:0] model(input logic [N-1:0] a, b, input logic c, s);
    logic [N-1:0] bb;
    logic [N:0]   sum;
    logic         o;
    bb  = s ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb} + {{N{1'b0}}, (s ? 1'b1 : c)};
    o   = (a[N-1] == bb[N-1]) && (sum[N-1] != a[N-1]);
    return {o, sum};
  endfunction

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  // One full operation; inputs are scrambled right after the start edge.
  task automatic do_op(input logic [N-1:0] a, b, input logic c, s,
                       input logic [N-1:0] er, input logic ec, eo, input string tag);
    int cyc, busy_cnt;
    start = 1'b1; op_a = a; op_b = b; cin = c; sub = s;
    tick();
    start = 1'b0;
    cyc = 0; busy_cnt = 0;
    while (done !== 1'b1 && cyc < 20) begin
      if (busy === 1'b1) busy_cnt++;
      op_a = rnd(); op_b = rnd(); cin = $urandom_range(1); sub = $urandom_range(1);
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(LIMBS));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(LIMBS));
    check({tag, "_result"}, 64'(result), 64'(er));
    check({tag, "_cout"}, 64'(cout), 64'(ec));
    check({tag, "_ovf"}, 64'(ovf), 64'(eo));
    tick();
    check({tag, "_done_pulse"}, 64'(done), 64'(0));
  endtask

  initial begin
    logic [N-1:0] a, b, r2;
    logic [N+1:0] m;
    logic         c, s;
    int           cyc, dn;

    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_cout", 64'(cout), 64'(0));
    check("rst_ovf", 64'(ovf), 64'(0));
    op_a = rnd(); op_b = rnd(); cin = 1'b1;
    repeat (3) tick();
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_result", 64'(result), 64'(0));

    do_op(28'h0000005, 28'h000000A, 1'b1, 1'b0, 28'h0000010, 1'b0, 1'b0, "add_small");
    do_op(28'hFFFFFFF, 28'h0000001, 1'b0, 1'b0, 28'h0000000, 1'b1, 1'b0, "ripple_wrap");
    do_op(28'h7FFFFFF, 28'h0000001, 1'b0, 1'b0, 28'h8000000, 1'b0, 1'b1, "pos_ovf");
    do_op(28'd100,     28'd27,      1'b0, 1'b1, 28'd73,      1'b1, 1'b0, "sub_100_27");
    do_op(28'h0000000, 28'h0000001, 1'b1, 1'b1, 28'hFFFFFFF, 1'b0, 1'b0, "sub_borrow");
    do_op(28'h8000000, 28'h0000001, 1'b0, 1'b1, 28'h7FFFFFF, 1'b1, 1'b1, "sub_ovf");

    start = 1'b0;
    repeat (3) tick();
    check("idle_hold_result", 64'(result), 64'(28'h7FFFFFF));
    check("idle_hold_ovf", 64'(ovf), 64'(1));

    // Reset after two RUN cycles abandons the operation.
    start = 1'b1; op_a = 28'h1234567; op_b = 28'h7654321; cin = 1'b0; sub = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_result", 64'(result), 64'(0));
    check("midrst_cout", 64'(cout), 64'(0));
    check("midrst_ovf", 64'(ovf), 64'(0));
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done === 1'b1) dn++;
    end
    check("midrst_no_done", 64'(dn), 64'(0));

    do_op(28'h1234567, 28'h7654321, 1'b0, 1'b0, 28'h8888888, 1'b0, 1'b1, "after_rst");

    // Starts during RUN and DONE are ignored; operands wiggle mid-run.
    a = 28'h0ABCDEF; b = 28'h0123456;
    start = 1'b1; op_a = a; op_b = b; cin = 1'b0; sub = 1'b0;
    tick();
    start = 1'b0;
    dn = 0;
    for (int i = 1; i <= 12; i++) begin
      op_a = rnd();
      tick();
      if (done === 1'b1) dn++;
      start = (i == 1 || i == 4);
    end
    start = 1'b0;
    m = model(a, b, 1'b0, 1'b0);
    check("proto_one_done", 64'(dn), 64'(1));
    check("proto_result", 64'(result), 64'(m[N-1:0]));
    check("proto_idle", 64'(busy), 64'(0));

    // Back-to-back: start held from the done cycle is taken one cycle later.
    a = 28'h0000FFF; b = 28'h0000001;
    start = 1'b1; op_a = a; op_b = b; cin = 1'b0; sub = 1'b0;
    tick();
    start = 1'b0;
    wait_done(cyc);
    check("b2b_first_latency", 64'(cyc), 64'(LIMBS));
    a = 28'h5555555; b = 28'h1111111;
    start = 1'b1; op_a = a; op_b = b; cin = 1'b0; sub = 1'b1;
    tick();
    check("b2b_idle_gap", 64'(busy), 64'(0));
    tick();
    check("b2b_accept", 64'(busy), 64'(1));
    start = 1'b0;
    wait_done(cyc);
    check("b2b_second_latency", 64'(cyc), 64'(LIMBS));
    r2 = 28'h4444444;
    check("b2b_result", 64'(result), 64'(r2));
    check("b2b_cout", 64'(cout), 64'(1));
    tick();

    for (int i = 0; i < 200; i++) begin
      a = rnd(); b = rnd();
      c = $urandom_range(1); s = $urandom_range(1);
      if (i % 20 == 0) a = {N{1'b1}};
      m = model(a, b, c, s);
      do_op(a, b, c, s, m[N-1:0], m[N], m[N+1], "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
